priority_interrupt_encoder: RTL and testbench



---
 rtl/priority_interrupt_encoder.sv | 101 ++++++++++
 tb/tb_priority_interrupt_encoder.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/priority_interrupt_encoder.sv
// Registered priority interrupt encoder: masked level/edge request capture,
// ack handshake, optional round-robin (PRIORITY_INTERRUPT_ENCODER_ROUND_ROBIN_EN).
// Ports: clk, resetN (async low), inputSignals, maskWrite, maskData, mask,
//        ack, anySignalActive, activeSignalIndex.
module priority_interrupt_encoder #(
  parameter int                  CHANNELS    = 16,
  parameter int                  INDEX_WIDTH = 4,
  parameter logic [CHANNELS-1:0] EDGE_MASK   = '0
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic [CHANNELS-1:0]    inputSignals,
  input  logic                   maskWrite,
  input  logic [CHANNELS-1:0]    maskData,
  output logic [CHANNELS-1:0]    mask,
  input  logic                   ack,
  output logic                   anySignalActive,
  output logic [INDEX_WIDTH-1:0] activeSignalIndex
);

  logic [CHANNELS-1:0]    prev_q, prev_d;
  logic [CHANNELS-1:0]    pend_q, pend_d;
  logic [CHANNELS-1:0]    mask_q, mask_d;
  logic [CHANNELS-1:0]    eff;
  logic [INDEX_WIDTH-1:0] idx;
  logic                   any;
  logic                   acc;

`ifdef PRIORITY_INTERRUPT_ENCODER_ROUND_ROBIN_EN
  logic [INDEX_WIDTH-1:0] ptr_q, ptr_d;
  int                     c;
`endif

  // Selection looks only at registers, so no input reaches the outputs.
  always_comb begin
    eff = pend_q & mask_q;
    any = |eff;
    idx = '0;
`ifdef PRIORITY_INTERRUPT_ENCODER_ROUND_ROBIN_EN
    c = 0;
    // Descending scan: last hit is the one nearest the pointer.
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      c = int'(ptr_q) + k;
      if (c >= CHANNELS) c = c - CHANNELS;
      if (eff[c]) idx = INDEX_WIDTH'(c);
    end
`else
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (eff[i]) idx = INDEX_WIDTH'(i);
    end
`endif
  end

  assign anySignalActive   = any;
  assign activeSignalIndex = idx;
  assign mask              = mask_q;
  assign acc               = ack & any;

  always_comb begin
    prev_d = inputSignals;
    mask_d = maskWrite ? maskData : mask_q;
    pend_d = pend_q;
    for (int i = 0; i < CHANNELS; i++) begin
      if (EDGE_MASK[i]) begin
        // A new rise beats a same-edge clear.
        pend_d[i] = (inputSignals[i] & ~prev_q[i]) |
                    (pend_q[i] & ~(acc && idx == INDEX_WIDTH'(i)));
      end else begin
        pend_d[i] = inputSignals[i];
      end
    end
  end

`ifdef PRIORITY_INTERRUPT_ENCODER_ROUND_ROBIN_EN
  always_comb begin
    ptr_d = ptr_q;
    if (acc) begin
      if (int'(idx) == CHANNELS - 1) ptr_d = '0;
      else                           ptr_d = idx + INDEX_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end
`endif

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      prev_q <= '0;
      pend_q <= '0;
      mask_q <= '0;
    end else begin
      prev_q <= prev_d;
      pend_q <= pend_d;
      mask_q <= mask_d;
    end
  end

endmodule

// File: tb/tb_priority_interrupt_encoder.sv
// Directed bench for priority_interrupt_encoder.
// Channels 4,5 edge-triggered; round-robin instance when macro defined.
module tb_priority_interrupt_encoder;

  logic        clk = 1'b0;
  logic        resetN = 1'b1;
  logic [15:0] inputSignals = '0;
  logic        maskWrite = 1'b0;
  logic [15:0] maskData = '0;
  logic [15:0] mask;
  logic        ack = 1'b0;
  logic        anySignalActive;
  logic [3:0]  activeSignalIndex;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  priority_interrupt_encoder #(
    .CHANNELS(16), .INDEX_WIDTH(4), .EDGE_MASK(16'h0030)
  ) dut (
    .clk(clk), .resetN(resetN),
    .inputSignals(inputSignals),
    .maskWrite(maskWrite), .maskData(maskData), .mask(mask),
    .ack(ack),
    .anySignalActive(anySignalActive),
    .activeSignalIndex(activeSignalIndex)
  );

`ifdef PRIORITY_INTERRUPT_ENCODER_ROUND_ROBIN_EN
  logic [4:0] in5 = '0;
  logic       mw5 = 1'b0;
  logic [4:0] md5 = '0;
  logic [4:0] m5;
  logic       ack5 = 1'b0;
  logic       any5;
  logic [2:0] idx5;

  priority_interrupt_encoder #(
    .CHANNELS(5), .INDEX_WIDTH(3), .EDGE_MASK(5'b0)
  ) dut_rr (
    .clk(clk), .resetN(resetN),
    .inputSignals(in5),
    .maskWrite(mw5), .maskData(md5), .mask(m5),
    .ack(ack5),
    .anySignalActive(any5),
    .activeSignalIndex(idx5)
  );
`endif

  task automatic chk(input string tag, input int got, input int exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2 resetN = 1'b0;
    #1;
    chk("rst_any", int'(anySignalActive), 0);
    chk("rst_idx", int'(activeSignalIndex), 0);
    chk("rst_mask", int'(mask), 0);
    step();
    step();
    resetN = 1'b1;

    maskWrite = 1'b1; maskData = 16'hFFFF;
    step();
    maskWrite = 1'b0;
    chk("mask_ff", int'(mask), 16'hFFFF);
    chk("idle_any", int'(anySignalActive), 0);
    chk("idle_idx", int'(activeSignalIndex), 0);

    inputSignals = 16'b1100100111001000;
    step();
    chk("lvl_any", int'(anySignalActive), 1);
    chk("lvl_idx", int'(activeSignalIndex), 3);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("lvl_ack_idx", int'(activeSignalIndex), 3);
    inputSignals = '0;
    step();
    chk("lvl_drop", int'(anySignalActive), 0);

    inputSignals = 16'h0030;
    step();
    inputSignals = '0;
    step();
    chk("edge_any", int'(anySignalActive), 1);
    chk("edge_idx4", int'(activeSignalIndex), 4);
    step();
    chk("edge_hold4", int'(activeSignalIndex), 4);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("edge_idx5", int'(activeSignalIndex), 5);
    chk("edge_any5", int'(anySignalActive), 1);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("edge_done", int'(anySignalActive), 0);

    inputSignals = 16'h0010;
    step();
    inputSignals = '0;
    maskWrite = 1'b1; maskData = 16'hFFEF;
    step();
    maskWrite = 1'b0;
    chk("mskd_mask", int'(mask), 16'hFFEF);
    chk("mskd_any", int'(anySignalActive), 0);
    ack = 1'b1;
    step();
    ack = 1'b0;
    maskWrite = 1'b1; maskData = 16'hFFFF;
    step();
    maskWrite = 1'b0;
    chk("unmsk_any", int'(anySignalActive), 1);
    chk("unmsk_idx", int'(activeSignalIndex), 4);
    inputSignals = 16'h0010; ack = 1'b1;
    step();
    inputSignals = '0; ack = 1'b0;
    chk("setwin_any", int'(anySignalActive), 1);
    chk("setwin_idx", int'(activeSignalIndex), 4);
    // Ack and mask write together: ack clears 4 using pre-write index.
    ack = 1'b1; maskWrite = 1'b1; maskData = 16'h00F0;
    step();
    ack = 1'b0; maskWrite = 1'b0;
    chk("ackmw_mask", int'(mask), 16'h00F0);
    chk("ackmw_any", int'(anySignalActive), 0);

    maskWrite = 1'b1; maskData = 16'hFFFF;
    inputSignals = 16'h0018;
    step();
    maskWrite = 1'b0;
    chk("pre_rst_idx", int'(activeSignalIndex), 3);
    #2 resetN = 1'b0;
    #1;
    chk("mid_rst_any", int'(anySignalActive), 0);
    chk("mid_rst_idx", int'(activeSignalIndex), 0);
    chk("mid_rst_mask", int'(mask), 0);
    inputSignals = '0;
    step();
    resetN = 1'b1;

`ifdef PRIORITY_INTERRUPT_ENCODER_ROUND_ROBIN_EN
    mw5 = 1'b1; md5 = 5'b11111; in5 = 5'b10011;
    step();
    mw5 = 1'b0;
    chk("rr_idx0", int'(idx5), 0);
    ack5 = 1'b1;
    step();
    chk("rr_idx1", int'(idx5), 1);
    step();
    chk("rr_idx4", int'(idx5), 4);
    step();
    ack5 = 1'b0;
    chk("rr_wrap0", int'(idx5), 0);
    chk("rr_any", int'(any5), 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
